tristate_bus_arbiter: RTL and testbench

Synchronous owner/arbiter for a shared multi-driver bus. It is the control and receive end for the tristate-driver cells our mux and passgate models use. It grants at most one agent's output enable at a time, with round-robin fairness and a break-before-make turnaround gap. It resolves the bus with a synthesizable AND-OR model and registers the resolved value for downstream logic. It sits between N driver agents and a single bus consumer.

---
 rtl/tristate_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter
//   Owner/arbiter and receive end for a shared multi-driver bus. Grants at
//   most one agent's tristate output enable at a time. The grant passes
//   round-robin, and an ownership lasts at most HOLD cycles when another
//   agent is waiting. Owners are separated by TURN dead cycles in which all
//   enables are low (break-before-make). The bus is resolved with an AND-OR
//   model and registered for the downstream consumer.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   req       per-agent level request [N]
//   wdata     per-agent drive data; agent i at [i*W +: W]
//   drive_en  one-hot or zero output enables to the agent drivers
//   owner     index of the current owner, valid while busy
//   busy      high while any drive_en bit is set
//   rd_data   registered resolved bus value
//   rd_valid  rd_data was updated this cycle
//   rd_src    agent that produced rd_data
module tristate_bus_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 8,
  parameter int TURN = 1,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   drive_en,
  output logic [IDW-1:0] owner,
  output logic           busy,
  output logic [W-1:0]   rd_data,
  output logic           rd_valid,
  output logic [IDW-1:0] rd_src
);

  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int TCW = (TURN > 1) ? $clog2(TURN) : 1;

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   drive_en_reg, drive_en_next;
  logic [IDW-1:0] owner_reg, owner_next;
  logic [IDW-1:0] last_owner_reg, last_owner_next;
  logic [HCW-1:0] hold_cnt_reg, hold_cnt_next;
  logic [TCW-1:0] gap_cnt_reg, gap_cnt_next;
  logic           busy_reg;
  logic [W-1:0]   rd_data_reg;
  logic           rd_valid_reg;
  logic [IDW-1:0] rd_src_reg;

  // Round-robin winner: first requester after last_owner, wrapping.
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           winner_found;
  logic [N-1:0]   grant_vec;

  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDW'((int'(last_owner_reg) + 1 + k) % N);
      if (!winner_found && req[cand]) begin
        winner_found = 1'b1;
        winner       = cand;
      end
    end
  end

  assign grant_vec = N'(1) << winner;

  // In OWN, drive_en_reg is the owner's one-hot mask, so it splits req into
  // "owner still wants the bus" and "someone else is waiting".
  logic any_req, owner_req, other_req, hold_sat, gap_last;
  assign any_req   = |req;
  assign owner_req = |(req & drive_en_reg);
  assign other_req = |(req & ~drive_en_reg);
  assign hold_sat  = (hold_cnt_reg == HCW'(HOLD - 1));
  assign gap_last  = (gap_cnt_reg == TCW'(TURN - 1));

  always_comb begin
    state_next      = state_reg;
    drive_en_next   = drive_en_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    hold_cnt_next   = hold_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next    = OWN;
          drive_en_next = grant_vec;
          owner_next    = winner;
          hold_cnt_next = '0;
        end
      end
      OWN: begin
        if (!owner_req || (hold_sat && other_req)) begin
          state_next      = GAP;
          drive_en_next   = '0;
          gap_cnt_next    = '0;
          last_owner_next = owner_reg;
        end else if (!hold_sat) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_last) begin
          if (any_req) begin
            // The previous owner can win again only if nobody else asks,
            // because the search starts just past it.
            state_next    = OWN;
            drive_en_next = grant_vec;
            owner_next    = winner;
            hold_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        drive_en_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      drive_en_reg   <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IDW'(N - 1);
      hold_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      drive_en_reg   <= drive_en_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      hold_cnt_reg   <= hold_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      busy_reg       <= |drive_en_next;
    end
  end

  // AND-OR bus resolution: an undriven bus reads as zero, never X/Z.
  logic [W-1:0] masked [N];
  logic [W-1:0] bus;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign masked[gi] = wdata[gi*W +: W] & {W{drive_en_reg[gi]}};
  end

  always_comb begin
    bus = '0;
    for (int i = 0; i < N; i++) begin
      bus = bus | masked[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_src_reg   <= '0;
    end else if (busy_reg) begin
      rd_data_reg  <= bus;
      rd_valid_reg <= 1'b1;
      rd_src_reg   <= owner_reg;
    end else begin
      rd_valid_reg <= 1'b0;
    end
  end

  assign drive_en = drive_en_reg;
  assign owner    = owner_reg;
  assign busy     = busy_reg;
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_src   = rd_src_reg;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N=4, W=8, HOLD=8). Instance a
// uses TURN=1 for the directed steps; instance b uses TURN=2 for a random
// contention run with per-cycle invariant checks.
module tb_tristate_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_a, req_b;
  logic [31:0] wdata_a, wdata_b;
  logic [3:0]  drive_en_a, drive_en_b;
  logic [1:0]  owner_a, owner_b, rd_src_a, rd_src_b;
  logic        busy_a, busy_b, rd_valid_a, rd_valid_b;
  logic [7:0]  rd_data_a, rd_data_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.N(4), .W(8), .HOLD(8), .TURN(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .wdata(wdata_a),
    .drive_en(drive_en_a), .owner(owner_a), .busy(busy_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_src(rd_src_a)
  );

  tristate_bus_arbiter #(.N(4), .W(8), .HOLD(8), .TURN(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .wdata(wdata_b),
    .drive_en(drive_en_b), .owner(owner_b), .busy(busy_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_src(rd_src_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp, input bit verbose);
    total++;
    assert (obs === exp) begin
      passed++;
      if (verbose) $display("check %s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Agent data: 0=1E, 1=4C, 2=A5, 3=D3
  logic [7:0] agent_data [4] = '{8'h1E, 8'h4C, 8'hA5, 8'hD3};

  initial begin
    logic [3:0]  prev_en;
    logic [31:0] prev_wd;
    logic [7:0]  exp_d;
    logic [1:0]  exp_src;
    int          zero_run;
    bit          had_owner;
    int          seq [5] = '{0, 1, 2, 3, 0};

    rst     = 1'b1;
    req_a   = '0;
    req_b   = '0;
    wdata_a = {8'hD3, 8'hA5, 8'h4C, 8'h1E};
    wdata_b = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_drive_en", drive_en_a, 0, 1);
    check("rst_busy",     busy_a,     0, 1);
    check("rst_owner",    owner_a,    0, 1);
    check("rst_rd_data",  rd_data_a,  0, 1);
    check("rst_rd_valid", rd_valid_a, 0, 1);
    check("rst_rd_src",   rd_src_a,   0, 1);

    // Single request from agent 2
    req_a = 4'b0100;
    tick();
    check("single_grant",   drive_en_a, 4'b0100, 1);
    check("single_busy",    busy_a,     1, 1);
    check("single_owner",   owner_a,    2, 1);
    check("single_rv_pre",  rd_valid_a, 0, 1);
    tick();
    check("single_rd_data", rd_data_a,  8'hA5, 1);
    check("single_rd_vld",  rd_valid_a, 1, 1);
    check("single_rd_src",  rd_src_a,   2, 1);
    req_a = 4'b0000;
    tick();
    check("single_release", drive_en_a, 0, 1);
    check("single_busy_lo", busy_a,     0, 1);
    tick();
    check("single_rv_lo",   rd_valid_a, 0, 1);
    check("single_rd_hold", rd_data_a,  8'hA5, 1);

    // All four requesting: owners 0,1,2,3,0, 8 cycles each, 1-cycle gap
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req_a = 4'b1111;
    tick();
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 8; c++) begin
        check($sformatf("rr_own%0d_c%0d", s, c), drive_en_a, 4'b0001 << seq[s], 1);
        if (c == 1) begin
          check($sformatf("rr_rd%0d", s), rd_data_a, agent_data[seq[s]], 1);
          check($sformatf("rr_src%0d", s), rd_src_a, seq[s], 1);
        end
        tick();
      end
      if (s < 4) begin
        check($sformatf("rr_gap%0d", s), drive_en_a, 0, 1);
        tick();
      end
    end

    // Early release of agent 1 while agent 3 waits
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req_a = 4'b0010;
    tick();
    check("early_grant1", drive_en_a, 4'b0010, 1);
    req_a = 4'b1010;
    tick(); tick();
    check("early_still1", drive_en_a, 4'b0010, 1);
    req_a = 4'b1000;
    tick();
    check("early_gap",    drive_en_a, 0, 1);
    tick();
    check("early_grant3", drive_en_a, 4'b1000, 1);
    tick();
    check("early_rd3",    rd_data_a,  8'hD3, 1);
    check("early_src3",   rd_src_a,   3, 1);

    // Lone owner: no forced release past HOLD
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req_a = 4'b0001;
    tick();
    for (int c = 0; c < 50; c++) begin
      check($sformatf("lone_c%0d", c), drive_en_a, 4'b0001, 1);
      tick();
    end

    // Reset mid-ownership, then priority restarts at agent 0
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req_a = 4'b0100;
    tick();
    check("midrst_own2", drive_en_a, 4'b0100, 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst_en",    drive_en_a, 0, 1);
    check("midrst_busy",  busy_a,     0, 1);
    check("midrst_owner", owner_a,    0, 1);
    check("midrst_rd",    rd_data_a,  0, 1);
    check("midrst_rv",    rd_valid_a, 0, 1);
    check("midrst_src",   rd_src_a,   0, 1);
    rst   = 1'b0;
    req_a = 4'b0101;
    tick();
    check("midrst_grant0", drive_en_a, 4'b0001, 1);
    check("midrst_owner0", owner_a,    0, 1);
    req_a = 4'b0000;

    // Random contention run on the TURN=2 instance
    prev_en   = '0;
    prev_wd   = '0;
    zero_run  = 0;
    had_owner = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      check("rnd_onehot", 32'($countones(drive_en_b) <= 1), 1, 0);
      if (prev_en != 0 && drive_en_b != 0)
        check("rnd_nochange", drive_en_b, prev_en, 0);
      if (drive_en_b != 0 && prev_en == 0 && had_owner)
        check("rnd_gap", 32'(zero_run >= 2), 1, 0);
      if (prev_en != 0) begin
        exp_d   = '0;
        exp_src = '0;
        for (int i = 0; i < 4; i++) begin
          if (prev_en[i]) begin
            exp_d   = prev_wd[i*8 +: 8];
            exp_src = 2'(i);
          end
        end
        check("rnd_rd_data", rd_data_b,  exp_d, 0);
        check("rnd_rd_src",  rd_src_b,   exp_src, 0);
        check("rnd_rd_vld",  rd_valid_b, 1, 0);
      end
      if (drive_en_b == 0) zero_run++;
      else zero_run = 0;
      if (drive_en_b != 0) had_owner = 1'b1;
      prev_en = drive_en_b;
      if ($urandom_range(0, 3) == 0) req_b = 4'($urandom_range(0, 15));
      wdata_b = $urandom;
      prev_wd = wdata_b;
    end
    $display("random run done: %0d cycles", 10000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
